// File: rtl/debug_snapshot_ctrl.sv
// debug_snapshot_ctrl
//   Owns the DUT debug address/data port and feeds the VGA debug text display.
//   Live mode: the display address passes straight through to the DUT.
//   Snapshot mode: on request, all 2^ADDR_W debug words are scanned into a local
//   buffer, so every row on screen comes from the same instant.
//
// Optional feature (macro SNAP_AUTO_EN): adds frame_tick_i. While idle, a frame
// tick starts a scan exactly like snap_req_i. A tick that arrives while busy is
// dropped.
//
// Ports
//   clk           system clock, all state changes on posedge
//   rst_n         asynchronous active-low reset
//   snap_req_i    one-cycle pulse, start a snapshot (ignored while busy)
//   live_mode_i   1 = live pass-through when idle, 0 = display the buffer
//   frame_tick_i  per-frame pulse (only with SNAP_AUTO_EN)
//   vga_addr_i    address requested by the display
//   vga_data_o    data returned to the display (combinational)
//   dut_addr_o    address driven to the DUT debug port
//   dut_data_i    data returned by the DUT debug port (SETTLE cycles after address)
//   busy_o        scan in progress (SCAN and DONE states)
//   done_o        one-cycle pulse when a scan completes
//   snap_valid_o  buffer holds one complete scan
//   snap_count_o  completed scans, wraps 255 -> 0
module debug_snapshot_ctrl #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snap_req_i,
    input  logic              live_mode_i,
`ifdef SNAP_AUTO_EN
    input  logic              frame_tick_i,
`endif
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic [DATA_W-1:0] vga_data_o,
    output logic [ADDR_W-1:0] dut_addr_o,
    input  logic [DATA_W-1:0] dut_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              snap_valid_o,
    output logic [7:0]        snap_count_o
);

    localparam int unsigned Depth = 1 << ADDR_W;
    // One extra bit so the last index never aliases back to 0 mid-scan.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(Depth - 1);
    localparam logic [1:0]      SettleCycles = 2'(SETTLE);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   issue_idx_q, issue_idx_d;
    logic [ADDR_W:0]   wr_idx_q, wr_idx_d;
    logic [1:0]        settle_q, settle_d;
    logic              snap_valid_q, snap_valid_d;
    logic [7:0]        snap_count_q, snap_count_d;
    logic              wr_en;
    logic              start;
    logic              live_sel;
    logic [DATA_W-1:0] snap_mem [Depth];

`ifdef SNAP_AUTO_EN
    assign start = snap_req_i | frame_tick_i;
`else
    assign start = snap_req_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            issue_idx_q  <= '0;
            wr_idx_q     <= '0;
            settle_q     <= '0;
            snap_valid_q <= 1'b0;
            snap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            wr_idx_q     <= wr_idx_d;
            settle_q     <= settle_d;
            snap_valid_q <= snap_valid_d;
            snap_count_q <= snap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_idx_d  = issue_idx_q;
        wr_idx_d     = wr_idx_q;
        settle_d     = settle_q;
        snap_valid_d = snap_valid_q;
        snap_count_d = snap_count_q;
        wr_en        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StScan;
                    issue_idx_d = '0;
                    wr_idx_d    = '0;
                    settle_d    = '0;
                end
            end
            StScan: begin
                if (issue_idx_q != LastIdx) begin
                    issue_idx_d = issue_idx_q + 1'b1;
                end
                // Writes lag issues by SETTLE cycles; after the initial delay one
                // word lands per cycle, tracking the issue stream.
                if (settle_q != SettleCycles) begin
                    settle_d = settle_q + 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d      = StIdle;
                snap_valid_d = 1'b1;
                snap_count_d = snap_count_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            snap_mem[wr_idx_q[ADDR_W-1:0]] <= dut_data_i;
        end
    end

    assign live_sel = (state_q == StIdle) && live_mode_i;

    always_comb begin
        dut_addr_o = live_sel ? vga_addr_i : issue_idx_q[ADDR_W-1:0];
        // Asynchronous read sees the pre-write word on a same-cycle collision.
        if (live_sel) begin
            vga_data_o = dut_data_i;
        end else if (snap_valid_q) begin
            vga_data_o = snap_mem[vga_addr_i];
        end else begin
            vga_data_o = '0;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign snap_valid_o = snap_valid_q;
    assign snap_count_o = snap_count_q;

endmodule

// File: tb/tb_debug_snapshot_ctrl.sv
// Bench for debug_snapshot_ctrl (ADDR_W=7, DATA_W=32, SETTLE=1).
// The DUT debug port is modelled as a memory read with one cycle of latency.
// The reference model is simply "after a completed scan, the buffer equals the
// DUT memory contents, valid=1, count+1".
module tb_debug_snapshot_ctrl;

    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snap_req = 1'b0;
    logic        live_mode = 1'b1;
    logic [6:0]  vga_addr = 7'h21;
    logic [31:0] vga_data;
    logic [6:0]  dut_addr;
    logic [31:0] dut_data = '0;
    logic        busy;
    logic        done;
    logic        snap_valid;
    logic [7:0]  snap_count;
`ifdef SNAP_AUTO_EN
    logic        frame_tick = 1'b0;
`endif

    debug_snapshot_ctrl #(
        .ADDR_W (7),
        .DATA_W (32),
        .SETTLE (1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snap_req_i   (snap_req),
        .live_mode_i  (live_mode),
`ifdef SNAP_AUTO_EN
        .frame_tick_i (frame_tick),
`endif
        .vga_addr_i   (vga_addr),
        .vga_data_o   (vga_data),
        .dut_addr_o   (dut_addr),
        .dut_data_i   (dut_data),
        .busy_o       (busy),
        .done_o       (done),
        .snap_valid_o (snap_valid),
        .snap_count_o (snap_count)
    );

    always #5 clk = ~clk;

    logic [31:0] dut_mem [N];
    always @(posedge clk) dut_data <= dut_mem[dut_addr];

    logic [31:0] exp_buf [N];
    bit          exp_valid = 1'b0;
    int          exp_count = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_vga(input logic [6:0] a);
        return exp_valid ? exp_buf[a] : 32'h0;
    endfunction

    task automatic model_scan_done();
        for (int a = 0; a < N; a++) exp_buf[a] = dut_mem[a];
        exp_valid = 1'b1;
        exp_count = (exp_count + 1) % 256;
    endtask

    task automatic pulse_start(input bit by_tick, input bit val);
`ifdef SNAP_AUTO_EN
        if (by_tick) frame_tick = val;
        else snap_req = val;
`else
        snap_req = val;
`endif
    endtask

    // Starts a scan and watches 200 cycles. Optionally re-requests at cycle
    // req_again_at or asserts reset at cycle rst_at (scan stops there).
    task automatic run_scan(input bit by_tick, input int req_again_at, input int rst_at,
                            input bit rand_live, output int busy_cycles, output int dones,
                            output int first_busy);
        busy_cycles = 0;
        dones       = 0;
        first_busy  = -1;
        @(negedge clk);
        vga_addr = 7'h7f;
        pulse_start(by_tick, 1'b1);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            pulse_start(by_tick, 1'b0);
            if (busy) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = i;
            end
            if (done) dones++;
            // Index 127 is rewritten last: mid-scan the old buffer word shows,
            // regardless of live_mode.
            if (i == 60) check_eq("midscan_old_word", vga_data, exp_vga(7'h7f));
            if (i == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            if (i == req_again_at) pulse_start(by_tick, 1'b1);
            if (rand_live) live_mode = 1'($urandom_range(0, 1));
        end
        pulse_start(by_tick, 1'b0);
        live_mode = 1'b0;
    endtask

    task automatic check_scan(input string tag, input int bc, input int dn, input int fb);
        check_eq({tag, "_busy_cycles"}, bc, 130);
        check_eq({tag, "_done_pulses"}, dn, 1);
        check_eq({tag, "_busy_latency"}, fb, 1);
        model_scan_done();
        check_eq({tag, "_count"}, snap_count, exp_count);
        check_eq({tag, "_valid"}, snap_valid, 1);
    endtask

    task automatic check_reads(input string tag, input int n);
        logic [6:0] a;
        for (int k = 0; k < n; k++) begin
            a = 7'($urandom_range(0, N - 1));
            vga_addr = a;
            #1;
            check_eq(tag, vga_data, exp_vga(a));
        end
    endtask

    initial begin
        int bc, dn, fb;
        for (int a = 0; a < N; a++) dut_mem[a] = {25'h0, 7'(a)};

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", snap_valid, 0);
        check_eq("rst_count", snap_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("live_dut_addr", dut_addr, 32'h21);
        check_eq("live_vga_data", vga_data, 32'h21);

        // Buffer mode before any scan reads zero
        live_mode = 1'b0;
        check_reads("noscan_zero", 8);

        // First snapshot
        for (int a = 0; a < N; a++) dut_mem[a] = 32'(a) ^ 32'hA5A5_0000;
        run_scan(1'b0, -1, -1, 1'b0, bc, dn, fb);
        check_scan("scan1", bc, dn, fb);
        vga_addr = 7'h7f;
        #1;
        check_eq("scan1_word7f", vga_data, 32'hA5A5_007F);
        check_reads("scan1_read", 8);

        // Frozen buffer vs live data
        for (int a = 0; a < N; a++) dut_mem[a] = 32'hDEAD_BEEF;
        check_reads("frozen_read", 6);
        live_mode = 1'b1;
        vga_addr  = 7'h15;
        @(posedge clk);
        @(negedge clk);
        check_eq("live_after_snap", vga_data, 32'hDEAD_BEEF);
        live_mode = 1'b0;

        // Random data, live_mode toggled during scans
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < N; a++) dut_mem[a] = $urandom;
            run_scan(1'b0, -1, -1, 1'b1, bc, dn, fb);
            check_scan("rand_scan", bc, dn, fb);
            check_reads("rand_read", 6);
        end

        // Request while busy and request coincident with DONE are ignored
        for (int a = 0; a < N; a++) dut_mem[a] = $urandom;
        run_scan(1'b0, 41, -1, 1'b0, bc, dn, fb);
        check_scan("req_busy", bc, dn, fb);
        run_scan(1'b0, 130, -1, 1'b0, bc, dn, fb);
        check_scan("req_done", bc, dn, fb);
        check_reads("req_read", 4);

        // Reset mid-scan
        for (int a = 0; a < N; a++) dut_mem[a] = $urandom;
        run_scan(1'b0, -1, 65, 1'b0, bc, dn, fb);
        #1;
        exp_valid = 1'b0;
        exp_count = 0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", snap_valid, 0);
        check_eq("midrst_count", snap_count, 0);
        check_reads("midrst_zero", 4);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SNAP_AUTO_EN
        // Frame ticks: each starts a scan; a tick while busy is dropped
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < N; a++) dut_mem[a] = $urandom;
            run_scan(1'b1, 50, -1, 1'b0, bc, dn, fb);
            check_scan("tick_scan", bc, dn, fb);
            check_reads("tick_read", 3);
            repeat (800 - 200) @(negedge clk);
        end
`endif

        // Run scans until the count wraps back to 0
        for (int a = 0; a < N; a++) dut_mem[a] = $urandom;
        while (exp_count != 0 || !exp_valid) begin
            @(negedge clk);
`ifdef SNAP_AUTO_EN
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
`else
            snap_req = 1'b1;
            @(negedge clk);
            snap_req = 1'b0;
`endif
            repeat (132) @(negedge clk);
            model_scan_done();
        end
        check_eq("count_wrap", snap_count, exp_count);
        check_eq("wrap_valid", snap_valid, 1);
        check_reads("wrap_read", 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
